// File: rtl/addr_seq_ctrl_if.sv
// Handshake bundle between the tile controller and the SRAM read-address sequencer.
// The controller drives start/base/hold; the sequencer drives address, enables and status.
interface addr_seq_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              hold;
    logic [ADDR_W-1:0] addr_serial_num;
    logic              rd_en;
    logic              data_valid;
    logic              data_first;
    logic              data_last;
    logic              busy;
    logic              done;
    logic              oob;

    modport master (
        output start, base_addr, hold,
        input  addr_serial_num, rd_en, data_valid, data_first, data_last, busy, done, oob
    );

    modport slave (
        input  start, base_addr, hold,
        output addr_serial_num, rd_en, data_valid, data_first, data_last, busy, done, oob
    );
endinterface

// File: rtl/addr_seq_ctrl.sv
// Read-address sequencer: issues NUM_STEPS saturating addresses from a latched base,
// tracks in-flight reads through a PIPE_LAT valid pipeline and pulses done once drained.
module addr_seq_ctrl #(
    parameter int NUM_STEPS = 63,
    parameter int PIPE_LAT  = 2,
    parameter int ADDR_W    = 7,
    parameter int ADDR_MAX  = 127
) (
    input  logic           clk,
    input  logic           rst,
    addr_seq_ctrl_if.slave bus
);
    localparam int               STEP_W    = 8;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [STEP_W-1:0]   step_r;
    logic                busy_r;
    logic                done_r;
    logic                oob_r;
    logic [PIPE_LAT-1:0] pipe_v_r;
    logic [PIPE_LAT-1:0] pipe_f_r;
    logic [PIPE_LAT-1:0] pipe_l_r;

    logic                issue_s;
    logic                first_s;
    logic                last_s;
    logic [ADDR_W:0]     start_sat_s;
    logic [ADDR_W:0]     next_sat_s;

    // Sum at 8 bits and clamp to ADDR_MAX; MSB of the result flags the clamp.
    function automatic logic [ADDR_W:0] sat_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [STEP_W-1:0] step);
        logic [STEP_W-1:0] sum;
        sum = STEP_W'(base) + step;
        if (sum > STEP_W'(ADDR_MAX)) begin
            sat_addr = {1'b1, ADDR_W'(ADDR_MAX)};
        end else begin
            sat_addr = {1'b0, sum[ADDR_W-1:0]};
        end
    endfunction

    // Issue qualification and the address for the following step.
    always_comb begin
        issue_s     = (state_r == RUN) && !bus.hold;
        first_s     = issue_s && (step_r == {STEP_W{1'b0}});
        last_s      = issue_s && (step_r == LAST_STEP);
        start_sat_s = sat_addr(bus.base_addr, {STEP_W{1'b0}});
        next_sat_s  = sat_addr(base_r, step_r + 8'd1);
    end

    // Sequencer FSM, address/status registers and in-flight valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            base_r   <= {ADDR_W{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            step_r   <= {STEP_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            oob_r    <= 1'b0;
            pipe_v_r <= {PIPE_LAT{1'b0}};
            pipe_f_r <= {PIPE_LAT{1'b0}};
            pipe_l_r <= {PIPE_LAT{1'b0}};
        end else begin
            pipe_v_r[0] <= issue_s;
            pipe_f_r[0] <= first_s;
            pipe_l_r[0] <= last_s;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_f_r[i] <= pipe_f_r[i-1];
                pipe_l_r[i] <= pipe_l_r[i-1];
            end
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the finishing tile.
                    if (bus.start && !done_r) begin
                        base_r  <= bus.base_addr;
                        step_r  <= {STEP_W{1'b0}};
                        addr_r  <= start_sat_s[ADDR_W-1:0];
                        oob_r   <= start_sat_s[ADDR_W];
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (issue_s) begin
                        if (step_r == LAST_STEP) begin
                            state_r <= DRAIN;
                        end else begin
                            step_r <= step_r + 8'd1;
                            addr_r <= next_sat_s[ADDR_W-1:0];
                            oob_r  <= oob_r | next_sat_s[ADDR_W];
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_v_r[PIPE_LAT-1] && pipe_l_r[PIPE_LAT-1]) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_serial_num = addr_r;
    assign bus.rd_en           = issue_s;
    assign bus.data_valid      = pipe_v_r[PIPE_LAT-1];
    assign bus.data_first      = pipe_f_r[PIPE_LAT-1];
    assign bus.data_last       = pipe_l_r[PIPE_LAT-1];
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.oob             = oob_r;
endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed bench for addr_seq_ctrl: default 63-step instance plus a 1-step instance.
module tb_addr_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    addr_seq_ctrl_if #(.ADDR_W(7)) ifa ();
    addr_seq_ctrl_if #(.ADDR_W(7)) ifb ();

    addr_seq_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa));
    addr_seq_ctrl #(.NUM_STEPS(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " addr"},  32'(ifa.addr_serial_num), 32'd0);
        check_val({tag, " rd_en"}, 32'(ifa.rd_en),           32'd0);
        check_val({tag, " dv"},    32'(ifa.data_valid),      32'd0);
        check_val({tag, " first"}, 32'(ifa.data_first),      32'd0);
        check_val({tag, " last"},  32'(ifa.data_last),       32'd0);
        check_val({tag, " busy"},  32'(ifa.busy),            32'd0);
        check_val({tag, " done"},  32'(ifa.done),            32'd0);
        check_val({tag, " oob"},   32'(ifa.oob),             32'd0);
    endtask

    // Start a tile at cycle 0 and observe cycles 1..ncyc; hs/hl give the hold window.
    task automatic run_tile(input string name, input logic [6:0] base, input int hs, input int hl,
                            input bit noise, input int ncyc, input int exp_last_rd,
                            input int exp_done, input int exp_oob_cyc);
        int k = 0, last_rd = 0, dv_cnt = 0, dv_first = 0, dv_last = 0;
        int f_cyc = 0, l_cyc = 0, done_cyc = 0, done_cnt = 0, busy_cnt = 0, busy_last = 0, oob_cyc = 0;
        logic [6:0] exp_addr;
        @(negedge clk);
        ifa.base_addr = base;
        ifa.start     = 1'b1;
        ifa.hold      = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            ifa.start = noise && (c == 5 || c == 40 || c == exp_done);
            ifa.hold  = (c >= hs) && (c < hs + hl);
            #1;
            exp_addr = (int'(base) + k > 127) ? 7'd127 : 7'(int'(base) + k);
            if (ifa.hold) begin
                check_val({name, " hold rd_en"}, 32'(ifa.rd_en), 32'd0);
                check_val({name, " hold addr"},  32'(ifa.addr_serial_num), 32'(exp_addr));
            end
            if (ifa.rd_en) begin
                check_val({name, " addr"}, 32'(ifa.addr_serial_num), 32'(exp_addr));
                k++;
                last_rd = c;
            end
            if (ifa.data_valid) begin
                dv_cnt++;
                if (dv_first == 0) dv_first = c;
                dv_last = c;
                if (ifa.data_first) f_cyc = c;
                if (ifa.data_last)  l_cyc = c;
            end
            if (ifa.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (ifa.busy) begin
                busy_cnt++;
                busy_last = c;
            end
            if (ifa.oob && oob_cyc == 0) oob_cyc = c;
        end
        ifa.hold = 1'b0;
        check_val({name, " issues"},     32'(k),         32'd63);
        check_val({name, " last rd_en"}, 32'(last_rd),   32'(exp_last_rd));
        check_val({name, " dv count"},   32'(dv_cnt),    32'd63);
        check_val({name, " dv first"},   32'(dv_first),  32'd3);
        check_val({name, " dv last"},    32'(dv_last),   32'(exp_last_rd + 2));
        check_val({name, " first cyc"},  32'(f_cyc),     32'd3);
        check_val({name, " last cyc"},   32'(l_cyc),     32'(exp_last_rd + 2));
        check_val({name, " done cyc"},   32'(done_cyc),  32'(exp_done));
        check_val({name, " done cnt"},   32'(done_cnt),  32'd1);
        check_val({name, " busy cnt"},   32'(busy_cnt),  32'(exp_done - 1));
        check_val({name, " busy last"},  32'(busy_last), 32'(exp_done - 1));
        check_val({name, " oob cyc"},    32'(oob_cyc),   32'(exp_oob_cyc));
        check_val({name, " oob final"},  32'(ifa.oob),   32'(exp_oob_cyc != 0));
    endtask

    initial begin
        int seen;
        ifa.start = 1'b0; ifa.base_addr = 7'd0; ifa.hold = 1'b0;
        ifb.start = 1'b0; ifb.base_addr = 7'd0; ifb.hold = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        check_val("reset b busy", 32'(ifb.busy), 32'd0);
        rst = 1'b0;

        run_tile("base0",   7'd0,   0,  0, 1'b0, 70, 63, 66, 0);
        run_tile("base100", 7'd100, 0,  0, 1'b0, 70, 63, 66, 29);
        run_tile("hold",    7'd0,   11, 3, 1'b0, 72, 66, 69, 0);
        run_tile("noise",   7'd0,   0,  0, 1'b1, 66, 63, 66, 0);

        // Cycle 67: start in IDLE right after done; cycle 68 shows the new tile.
        @(negedge clk);
        ifa.start = 1'b1; ifa.base_addr = 7'd33;
        #1;
        check_val("post done idle rd_en", 32'(ifa.rd_en), 32'd0);
        check_val("post done low",        32'(ifa.done),  32'd0);
        @(negedge clk);
        ifa.start = 1'b0;
        #1;
        check_val("restart rd_en", 32'(ifa.rd_en),           32'd1);
        check_val("restart addr",  32'(ifa.addr_serial_num), 32'd33);
        check_val("restart busy",  32'(ifa.busy),            32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Abort mid-tile at step 20 with oob already set by base 110.
        @(negedge clk);
        ifa.base_addr = 7'd110; ifa.start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            ifa.start = 1'b0;
        end
        #1;
        check_val("abort pre addr", 32'(ifa.addr_serial_num), 32'd127);
        check_val("abort pre oob",  32'(ifa.oob),             32'd1);
        check_val("abort pre dv",   32'(ifa.data_valid),      32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (ifa.rd_en || ifa.data_valid || ifa.done || ifa.busy) seen++;
        end
        check_val("abort quiet", 32'(seen), 32'd0);

        // Single-step instance: issue at 1, data at 3 with first and last, done at 4.
        @(negedge clk);
        ifb.base_addr = 7'd5; ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        #1;
        check_val("one c1 rd_en", 32'(ifb.rd_en),           32'd1);
        check_val("one c1 addr",  32'(ifb.addr_serial_num), 32'd5);
        check_val("one c1 busy",  32'(ifb.busy),            32'd1);
        @(negedge clk);
        #1;
        check_val("one c2 rd_en", 32'(ifb.rd_en),      32'd0);
        check_val("one c2 dv",    32'(ifb.data_valid), 32'd0);
        @(negedge clk);
        #1;
        check_val("one c3 dv",    32'(ifb.data_valid), 32'd1);
        check_val("one c3 first", 32'(ifb.data_first), 32'd1);
        check_val("one c3 last",  32'(ifb.data_last),  32'd1);
        check_val("one c3 done",  32'(ifb.done),       32'd0);
        @(negedge clk);
        #1;
        check_val("one c4 done",  32'(ifb.done),       32'd1);
        check_val("one c4 dv",    32'(ifb.data_valid), 32'd0);
        check_val("one c4 busy",  32'(ifb.busy),       32'd0);
        @(negedge clk);
        #1;
        check_val("one c5 done",  32'(ifb.done),       32'd0);
        check_val("one c5 addr",  32'(ifb.addr_serial_num), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addr_seq_ctrl.md
Name: addr_seq_ctrl

Overview:
- Sequencer for the weight/data SRAM read-address path. On `start` it walks `addr_serial_num` through one tile's queue: NUM_STEPS consecutive addresses from a latched base.
- The address select stage downstream registers the address. The SRAM adds read latency on top of that.
- This block issues read enables, tracks in-flight reads through a PIPE_LAT-deep valid pipeline and flags when returned operand data is valid.
- It pulses `done` after the last read has drained.
- It sits between the tile-level controller and the address select/SRAM datapath that feeds the systolic array.

Parameters:
- NUM_STEPS, 63, addresses issued per tile (32+32-1 skewed queue length); legal 1..128.
- PIPE_LAT, 2, cycles from address issue to SRAM data valid (address register 1 + SRAM read 1); legal 1..4.
- ADDR_W, 7, width of `addr_serial_num`.
- ADDR_MAX, 127, highest legal SRAM word address.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a tile; sampled only in IDLE.
- base_addr  input  7  first serial address; latched when `start` is accepted.
- hold  input  1  stall request from downstream; freezes address issue.
- addr_serial_num  output  7  current serial address to the address select stage.
- rd_en  output  1  address on `addr_serial_num` is a real issue this cycle.
- data_valid  output  1  SRAM read data for an issued address is valid this cycle.
- data_first  output  1  with `data_valid`, marks the data for step 0.
- data_last  output  1  with `data_valid`, marks the data for step NUM_STEPS-1.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse on completion.
- oob  output  1  sticky; base+step exceeded ADDR_MAX during this tile.

Behaviour:
- Reset: all outputs are 0 at reset: addr_serial_num=0, rd_en=0, data_valid=0, data_first=0, data_last=0, busy=0, done=0, oob=0. FSM goes to IDLE, step counter=0, valid pipeline cleared. Reset mid-tile aborts immediately: no `done`, and in-flight valids are discarded.
- IDLE:
  - `start`=1 latches `base_addr`, clears step and `oob`, and moves to RUN on the next cycle.
  - `done` is 0 in any cycle after its pulse.
  - `addr_serial_num` holds its last value.
- RUN:
  - If `hold`=0: `rd_en`=1, `addr_serial_num`=sat(base+step), step increments.
  - After the issue with step=NUM_STEPS-1, move to DRAIN.
  - If `hold`=1: `rd_en`=0; step and address freeze; the valid pipeline still shifts (a 0 is inserted).
  - `start` is ignored while `busy`=1.
- Address arithmetic: compute base+step at 8 bits.
  - If the sum is > ADDR_MAX, output ADDR_MAX and set `oob`=1. `oob` stays set until the next accepted `start` or reset.
  - No wrap-around ever occurs.
- Valid pipeline: PIPE_LAT-stage shift register of {rd_en, is_first, is_last}. `data_valid`/`data_first`/`data_last` are the tail of this register, i.e. exactly PIPE_LAT cycles after the matching `rd_en`.
- DRAIN:
  - `rd_en`=0, and `hold` is don't-care.
  - Wait until the pipeline is empty, i.e. the cycle `data_last`=1 has been output.
  - On the next cycle, assert `done`=1 for one cycle, drop `busy`, and return to IDLE.
- `start` in the same cycle as `done`: ignored. The FSM is still leaving DRAIN. A new tile requires `start` in IDLE, at the earliest the cycle after `done`.
- NUM_STEPS=1: one issue carries both `data_first` and `data_last` on the same beat.
- Latency:
  - `start` accepted at cycle t: first `rd_en` at t+1.
  - Last `rd_en` at t+NUM_STEPS + (hold cycles).
  - `done` at the last `rd_en` + PIPE_LAT + 1.
- Throughput: one address per cycle when `hold`=0.

Test Plan:
- Reset, then `start` with base_addr=0, hold=0, NUM_STEPS=63, PIPE_LAT=2:
  - `addr_serial_num` is 0..62 on consecutive `rd_en` cycles 1..63.
  - `data_valid` is high on cycles 3..65; `data_first`@3, `data_last`@65.
  - `done` pulses @66; `busy` is high for cycles 1..65.
- base_addr=100: addresses 100..127 are issued, then 127 repeats for the remaining 35 issues; `oob` goes high on the 29th issue and stays high after `done`.
- `hold`=1 for 3 cycles starting at step 10: `rd_en`=0 and the address holds at 10 for 3 cycles; `data_valid` shows a 3-cycle gap; `done` arrives 3 cycles later than in scenario 1.
- `start` pulsed at cycles 5, 40 and in the `done` cycle: all ignored; exactly one `done` pulse; a `start` one cycle after `done` begins a new tile with addr=base.
- `rst`=1 at step 20 with 2 reads in flight: next cycle all outputs are 0, no `data_valid`/`done` follows, and FSM is in IDLE.
- NUM_STEPS=1, base_addr=5: one `rd_en` with addr 5; `data_valid` with `data_first`=`data_last`=1 two cycles later; `done` the cycle after.
